alu_result_fifo: RTL and testbench



---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_flag_gen.sv | 21 ++
 rtl/alu_result_fifo.sv | 92 +++++++++
 tb/tb_alu_result_fifo.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types for the ALU result buffer
// ALU_RESULT_PARITY_EN adds a parity bit to the flag and entry types.
package alu_pkg;

  localparam int ALU_CTRL_W = 4;
  localparam int ALU_DATA_W = 32;

  typedef struct packed {
    logic zero;
    logic neg;
`ifdef ALU_RESULT_PARITY_EN
    logic parity;
`endif
  } alu_flags_t;

  typedef struct packed {
    logic [ALU_CTRL_W-1:0] control;
    logic [ALU_DATA_W-1:0] result;
    logic                  zero;
    logic                  neg;
`ifdef ALU_RESULT_PARITY_EN
    logic                  parity;
`endif
  } alu_entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - zero/negative status flags for one ALU result
// ALU_RESULT_PARITY_EN adds an even-parity (XOR-reduce) flag.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic [SIZE-1:0] result,
  output alu_flags_t      flags
);

  always_comb begin
    flags      = '0;
    flags.zero = (result == '0);
    flags.neg  = result[SIZE-1];
`ifdef ALU_RESULT_PARITY_EN
    flags.parity = ^result;
`endif
  end

endmodule

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - valid/ready FIFO capturing ALU results with flags
// ALU_RESULT_PARITY_EN adds a stored parity bit and the out_parity port.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ALU_CTRL_W-1:0]      in_control,
  input  logic [SIZE-1:0]            in_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ALU_CTRL_W-1:0]      out_control,
  output logic [SIZE-1:0]            out_result,
  output logic                       out_zero,
  output logic                       out_neg,
`ifdef ALU_RESULT_PARITY_EN
  output logic                       out_parity,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [SIZE-1:0]       mem_result [DEPTH];
  logic [ALU_CTRL_W-1:0] mem_control [DEPTH];
  alu_flags_t            mem_flags [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  alu_flags_t       in_flags;
  alu_flags_t       head_flags;

  alu_flag_gen #(.SIZE(SIZE)) u_flag_gen (
    .result (in_result),
    .flags  (in_flags)
  );

  // Handshake depends only on the registered count: no ready/valid feed-through.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Entry storage is intentionally left unreset; validity comes from count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr]  <= in_result;
      mem_control[wr_ptr] <= in_control;
      mem_flags[wr_ptr]   <= in_flags;
    end
  end

  always_comb begin
    out_result  = '0;
    out_control = '0;
    head_flags  = '0;
    if (out_valid) begin
      out_result  = mem_result[rd_ptr];
      out_control = mem_control[rd_ptr];
      head_flags  = mem_flags[rd_ptr];
    end
  end

  assign out_zero = head_flags.zero;
  assign out_neg  = head_flags.neg;
`ifdef ALU_RESULT_PARITY_EN
  assign out_parity = head_flags.parity;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb/tb_alu_result_fifo.sv - scoreboard bench for alu_result_fifo
// Parity checks are compiled in when ALU_RESULT_PARITY_EN is defined.
module tb_alu_result_fifo;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] r;
  } exp_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [3:0]  in_control = '0;
  logic [31:0] in_result = '0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [3:0]  out_control;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_neg;
`ifdef ALU_RESULT_PARITY_EN
  logic        out_parity;
`endif
  logic [2:0]  count;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  alu_result_fifo #(.SIZE(32), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_control  (in_control),
    .in_result   (in_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_control (out_control),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_neg     (out_neg),
`ifdef ALU_RESULT_PARITY_EN
    .out_parity  (out_parity),
`endif
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted head, checks idle zeroing otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pop_control", 64'(out_control), 64'(e.c));
          chk("pop_result", 64'(out_result), 64'(e.r));
          chk("pop_zero", 64'(out_zero), 64'(e.r == 32'h0));
          chk("pop_neg", 64'(out_neg), 64'(e.r[31]));
`ifdef ALU_RESULT_PARITY_EN
          chk("pop_parity", 64'(out_parity), 64'(^e.r));
`endif
        end
      end else if (!out_valid) begin
          chk("idle_zeroed", 64'({out_control, out_result, out_zero, out_neg}), 64'h0);
      end
    end
  end

  task automatic push_word(input logic [3:0] c, input logic [31:0] r);
    bit done;
    exp_t e;
    done = 0;
    @(posedge clk); #1;
    in_valid = 1; in_control = c; in_result = r;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.c = c; e.r = r;
        exp_q.push_back(e);
        done = 1;
      end
    end
    if (!done) chk("push_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    @(posedge clk); #1;
    out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!out_valid) break;
    end
    chk("drain_count", 64'(count), 64'd0);
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  initial begin
    #12;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_result", 64'(out_result), 64'd0);
    rst_n = 1;

    // Zero result: flags on the head one cycle after the push.
    push_word(4'h3, 32'h0000_0000);
    @(negedge clk);
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_out_zero", 64'(out_zero), 64'd1);
    chk("t1_out_neg", 64'(out_neg), 64'd0);
    chk("t1_count", 64'(count), 64'd1);
    drain();

    // Fill, hold a fifth producer word, then drain in order.
    push_word(4'h1, 32'h8000_0001);
    push_word(4'h2, 32'h0000_0001);
    push_word(4'h3, 32'h0000_0002);
    push_word(4'h4, 32'h0000_0003);
    @(posedge clk); #1;
    in_valid = 1; in_control = 4'h5; in_result = 32'hAAAA_5555;
    repeat (3) begin
      @(negedge clk);
      chk("t2_full_count", 64'(count), 64'd4);
      chk("t2_full_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    chk("t2_first_neg", 64'(out_neg), 64'd1);
    chk("t2_first_result", 64'(out_result), 64'h8000_0001);
    drain();

    // Full with pop and push offered: pop only, push lands next cycle.
    push_word(4'h6, 32'h0000_0010);
    push_word(4'h7, 32'hFFFF_FFFF);
    push_word(4'h8, 32'h0000_0012);
    push_word(4'h9, 32'h0000_0013);
    @(posedge clk); #1;
    in_valid = 1; in_control = 4'hA; in_result = 32'h1234_5678; out_ready = 1;
    @(negedge clk);
    chk("t4_full_in_ready", 64'(in_ready), 64'd0);
    chk("t4_full_count", 64'(count), 64'd4);
    @(posedge clk); #1;
    out_ready = 0;
    @(negedge clk);
    chk("t4_after_pop_count", 64'(count), 64'd3);
    chk("t4_after_pop_in_ready", 64'(in_ready), 64'd1);
    begin
      exp_t e;
      e.c = 4'hA; e.r = 32'h1234_5678;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    chk("t4_refill_count", 64'(count), 64'd4);

    // Pop one to reach count=3, then reset asynchronously mid-cycle.
    @(posedge clk); #1;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    @(negedge clk);
    chk("t5_pre_reset_count", 64'(count), 64'd3);
    #1 rst_n = 0;
    #1;
    chk("t5_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_count", 64'(count), 64'd0);
    chk("t5_rst_out_result", 64'(out_result), 64'd0);
    chk("t5_rst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1;

    // Steady state at count=2 with simultaneous push and pop, pointers wrap.
    push_word(4'h0, 32'h0000_0100);
    push_word(4'h1, 32'h0000_0101);
    for (int i = 0; i < 20; i++) begin
      exp_t e;
      @(posedge clk); #1;
      in_valid = 1; out_ready = 1;
      in_control = 4'(i + 2); in_result = 32'h0000_0102 + 32'(i);
      @(negedge clk);
      chk("t3_steady_count", 64'(count), 64'd2);
      if (in_ready) begin
        e.c = in_control; e.r = in_result;
        exp_q.push_back(e);
      end else begin
        chk("t3_steady_in_ready", 64'(in_ready), 64'd1);
      end
    end
    @(posedge clk); #1;
    in_valid = 0; out_ready = 0;
    @(negedge clk);
    chk("t3_end_count", 64'(count), 64'd2);
    drain();

    // Parity of the head entry.
    push_word(4'hB, 32'h0000_0007);
    @(negedge clk);
    chk("t6_head_7", 64'(out_result), 64'h7);
`ifdef ALU_RESULT_PARITY_EN
    chk("t6_parity_7", 64'(out_parity), 64'd1);
`endif
    drain();
    push_word(4'hC, 32'h0000_0003);
    @(negedge clk);
    chk("t6_head_3", 64'(out_result), 64'h3);
`ifdef ALU_RESULT_PARITY_EN
    chk("t6_parity_3", 64'(out_parity), 64'd0);
`endif
    drain();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
